// File: rtl/lfsr_period_meter.sv
// Measures the recurrence period of a sampled generator state, plus the ones count, zero lock-up and timeout flags.
// Define LFSR_PERIOD_METER_ONES_COUNT_EN to build the ones accumulator; otherwise ones_count is tied to 0.
module lfsr_period_meter #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 10
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_state,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  period,
   output logic [CNT_W-1:0]  ones_count,
   output logic              zero_seen,
   output logic              timeout
);
   typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] ref_q, ref_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  period_q, period_d;
   logic              zero_seen_q, zero_seen_d;
   logic              timeout_q, timeout_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              arm_take, meas_take, match, hit_limit;
   logic [CNT_W-1:0]  cnt_inc;

   // A start in the same cycle as a valid sample wins; that sample is dropped.
   assign arm_take  = !start && (state_q == ARM) && in_valid;
   assign meas_take = !start && (state_q == MEASURE) && in_valid;
   assign cnt_inc   = cnt_q + 1'b1;
   assign match     = (in_state == ref_q);
   assign hit_limit = (cnt_inc == CNT_MAX);

   always_comb begin
      state_d     = state_q;
      ref_d       = ref_q;
      cnt_d       = cnt_q;
      period_d    = period_q;
      zero_seen_d = zero_seen_q;
      timeout_d   = timeout_q;
      if (start) begin
         state_d     = ARM;
         cnt_d       = '0;
         period_d    = '0;
         zero_seen_d = 1'b0;
         timeout_d   = 1'b0;
      end else if (arm_take) begin
         ref_d   = in_state;
         cnt_d   = '0;
         state_d = MEASURE;
         if (in_state == '0) zero_seen_d = 1'b1;
      end else if (meas_take) begin
         cnt_d = cnt_inc;
         if (match) begin
            period_d = cnt_inc;
            state_d  = DONE;
         end else begin
            if (in_state == '0) zero_seen_d = 1'b1;
            if (hit_limit) begin
               timeout_d = 1'b1;
               period_d  = '0;
               state_d   = DONE;
            end
         end
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
      busy_d = (state_d == ARM) || (state_d == MEASURE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         ref_q       <= '0;
         cnt_q       <= '0;
         period_q    <= '0;
         zero_seen_q <= 1'b0;
         timeout_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ref_q       <= ref_d;
         cnt_q       <= cnt_d;
         period_q    <= period_d;
         zero_seen_q <= zero_seen_d;
         timeout_q   <= timeout_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

`ifdef LFSR_PERIOD_METER_ONES_COUNT_EN
   logic [CNT_W-1:0] ones_acc_q, ones_acc_d;
   logic [CNT_W-1:0] ones_q, ones_d;

   always_comb begin
      ones_acc_d = ones_acc_q;
      ones_d     = ones_q;
      if (start) begin
         ones_acc_d = '0;
         ones_d     = '0;
      end else if (arm_take) begin
         ones_acc_d = {{(CNT_W-1){1'b0}}, in_state[0]};
      end else if (meas_take) begin
         if (match) ones_d = ones_acc_q;
         else if (hit_limit) ones_d = '0;
         else ones_acc_d = ones_acc_q + {{(CNT_W-1){1'b0}}, in_state[0]};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ones_acc_q <= '0;
         ones_q     <= '0;
      end else begin
         ones_acc_q <= ones_acc_d;
         ones_q     <= ones_d;
      end
   end

   assign ones_count = ones_q;
`else
   assign ones_count = '0;
`endif

   assign busy      = busy_q;
   assign done      = done_q;
   assign period    = period_q;
   assign zero_seen = zero_seen_q;
   assign timeout   = timeout_q;
endmodule

// File: tb/tb_lfsr_period_meter.sv
// Directed bench for lfsr_period_meter: a CNT_W=10 instance and a CNT_W=8 instance share all stimulus.
module tb_lfsr_period_meter;
   logic       clock = 1'b0;
   logic       reset, start, in_valid;
   logic [7:0] in_state;
   logic       busy, done, zero_seen, timeout;
   logic [9:0] period, ones_count;
   logic       busy8, done8, zero8, timeout8;
   logic [7:0] period8, ones8;

`ifdef LFSR_PERIOD_METER_ONES_COUNT_EN
   localparam int ONES_EN = 1;
`else
   localparam int ONES_EN = 0;
`endif

   int         checks = 0, errors = 0;
   int         done_cnt = 0, done8_cnt = 0;
   int         mode;
   logic [7:0] src;
   bit         toggle;

   lfsr_period_meter #(.DATA_W(8), .CNT_W(10)) dut (
      .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_state(in_state),
      .busy(busy), .done(done), .period(period), .ones_count(ones_count),
      .zero_seen(zero_seen), .timeout(timeout));

   lfsr_period_meter #(.DATA_W(8), .CNT_W(8)) dut8 (
      .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_state(in_state),
      .busy(busy8), .done(done8), .period(period8), .ones_count(ones8),
      .zero_seen(zero8), .timeout(timeout8));

   always #5 clock = ~clock;

   // mode 0: Fibonacci LFSR taps 8,6,5,4; mode 1: constant; mode 2: incrementing counter
   function automatic logic [7:0] next_src(input logic [7:0] s);
      case (mode)
         0:       return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
         2:       return s + 8'd1;
         default: return s;
      endcase
   endfunction

   task automatic cycle();
      @(posedge clock);
      #1;
      if (done)  done_cnt++;
      if (done8) done8_cnt++;
      if (in_valid) src = next_src(src);
      if (toggle) in_valid = ~in_valid;
      in_state = in_valid ? src : ~src;
   endtask

   task automatic set_src(input int m, input logic [7:0] v, input bit tog);
      mode     = m;
      src      = v;
      toggle   = tog;
      in_valid = 1'b1;
      in_state = v;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cycle();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int n, output bit ok);
      n  = 0;
      ok = 1'b0;
      while (n < budget && !ok) begin
         cycle();
         n++;
         if (done) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_state = 8'h00;
      mode = 1; src = 8'h00; toggle = 1'b0;
      cycle(); cycle();
      checks++;
      if ({busy, done, period, ones_count, zero_seen, timeout} !== 24'd0) begin
         errors++; $display("FAIL reset_outputs: got %h required 0", {busy, done, period, ones_count, zero_seen, timeout});
      end
      checks++;
      if ({busy8, done8, period8, ones8, zero8, timeout8} !== 20'd0) begin
         errors++; $display("FAIL reset_outputs8: got %h required 0", {busy8, done8, period8, ones8, zero8, timeout8});
      end
      reset = 1'b0;
      cycle(); cycle();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL idle_after_reset: busy=%b done=%b required 0 0", busy, done);
      end
   endtask

   task automatic test_lfsr();
      int n; bit ok; int d0;
      int exp_ones = ONES_EN ? 128 : 0;
      set_src(0, 8'h01, 1'b0);
      d0 = done_cnt;
      pulse_start();
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++; $display("FAIL busy_after_start: busy=%b done=%b required 1 0", busy, done);
      end
      wait_done(400, n, ok);
      checks++;
      if (!ok || n != 256) begin
         errors++; $display("FAIL lfsr_latency: ok=%0d cycles=%0d required 1 256", ok, n);
      end
      checks++;
      if (period !== 10'd255 || ones_count !== 10'(exp_ones) || zero_seen !== 1'b0 || timeout !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL lfsr_result: period=%0d ones=%0d zero=%b to=%b busy=%b required 255 %0d 0 0 0",
                            period, ones_count, zero_seen, timeout, busy, exp_ones);
      end
      checks++;
      if (period8 !== 8'd255 || ones8 !== 8'(exp_ones) || timeout8 !== 1'b0) begin
         errors++; $display("FAIL lfsr_match_at_limit8: period=%0d ones=%0d to=%b required 255 %0d 0", period8, ones8, timeout8, exp_ones);
      end
      cycle();
      checks++;
      if (done !== 1'b0) begin
         errors++; $display("FAIL done_one_cycle: done=%b required 0", done);
      end
      repeat (5) cycle();
      checks++;
      if (period !== 10'd255 || done_cnt - d0 != 1) begin
         errors++; $display("FAIL lfsr_hold: period=%0d dones=%0d required 255 1", period, done_cnt - d0);
      end
   endtask

   task automatic test_gapped();
      int n; bit ok;
      int exp_ones = ONES_EN ? 128 : 0;
      set_src(0, 8'h01, 1'b1);
      pulse_start();
      wait_done(700, n, ok);
      toggle = 1'b0;
      checks++;
      if (!ok || n != 512) begin
         errors++; $display("FAIL gapped_latency: ok=%0d cycles=%0d required 1 512", ok, n);
      end
      checks++;
      if (period !== 10'd255 || ones_count !== 10'(exp_ones) || timeout !== 1'b0) begin
         errors++; $display("FAIL gapped_result: period=%0d ones=%0d to=%b required 255 %0d 0", period, ones_count, timeout, exp_ones);
      end
   endtask

   task automatic test_constant(input logic [7:0] v);
      int n; bit ok;
      int exp_ones = ONES_EN ? int'(v[0]) : 0;
      set_src(1, v, 1'b0);
      pulse_start();
      wait_done(10, n, ok);
      checks++;
      if (!ok || n != 2) begin
         errors++; $display("FAIL const_latency_%h: ok=%0d cycles=%0d required 1 2", v, ok, n);
      end
      checks++;
      if (period !== 10'd1 || ones_count !== 10'(exp_ones) || zero_seen !== (v == 8'h00) || timeout !== 1'b0) begin
         errors++; $display("FAIL const_result_%h: period=%0d ones=%0d zero=%b to=%b required 1 %0d %b 0",
                            v, period, ones_count, zero_seen, timeout, exp_ones, (v == 8'h00));
      end
      checks++;
      if (period8 !== 8'd1 || zero8 !== (v == 8'h00)) begin
         errors++; $display("FAIL const_result8_%h: period=%0d zero=%b required 1 %b", v, period8, zero8, (v == 8'h00));
      end
   endtask

   task automatic test_increment();
      int n; bit ok; int d8;
      int exp_ones = ONES_EN ? 128 : 0;
      set_src(2, 8'h10, 1'b0);
      d8 = done8_cnt;
      pulse_start();
      wait_done(400, n, ok);
      checks++;
      if (!ok || n != 257) begin
         errors++; $display("FAIL incr_latency: ok=%0d cycles=%0d required 1 257", ok, n);
      end
      checks++;
      if (period !== 10'd256 || ones_count !== 10'(exp_ones) || zero_seen !== 1'b1 || timeout !== 1'b0) begin
         errors++; $display("FAIL incr_result: period=%0d ones=%0d zero=%b to=%b required 256 %0d 1 0",
                            period, ones_count, zero_seen, timeout, exp_ones);
      end
      checks++;
      if (timeout8 !== 1'b1 || period8 !== 8'd0 || ones8 !== 8'd0 || zero8 !== 1'b1 || done8_cnt - d8 != 1) begin
         errors++; $display("FAIL incr_timeout8: to=%b period=%0d ones=%0d zero=%b dones=%0d required 1 0 0 1 1",
                            timeout8, period8, ones8, zero8, done8_cnt - d8);
      end
   endtask

   task automatic test_restart();
      int n; bit ok; int d0;
      set_src(0, 8'h01, 1'b0);
      d0 = done_cnt;
      pulse_start();
      repeat (50) cycle();
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL restart_busy: busy=%b required 1", busy);
      end
      pulse_start();
      wait_done(400, n, ok);
      checks++;
      if (!ok || n != 256 || period !== 10'd255 || done_cnt - d0 != 1) begin
         errors++; $display("FAIL restart_result: ok=%0d cycles=%0d period=%0d dones=%0d required 1 256 255 1",
                            ok, n, period, done_cnt - d0);
      end
   endtask

   task automatic test_reset_mid();
      int n; bit ok; int d0;
      set_src(2, 8'hF0, 1'b0);
      pulse_start();
      repeat (100) cycle();
      checks++;
      if (busy !== 1'b1 || zero_seen !== 1'b1) begin
         errors++; $display("FAIL mid_precondition: busy=%b zero=%b required 1 1", busy, zero_seen);
      end
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      checks++;
      if ({busy, done, period, ones_count, zero_seen, timeout} !== 24'd0 ||
          {busy8, done8, period8, ones8, zero8, timeout8} !== 20'd0) begin
         errors++; $display("FAIL mid_reset_outputs: got %h / %h required 0 / 0",
                            {busy, done, period, ones_count, zero_seen, timeout}, {busy8, done8, period8, ones8, zero8, timeout8});
      end
      d0 = done_cnt;
      repeat (300) cycle();
      checks++;
      if (done_cnt != d0 || busy !== 1'b0) begin
         errors++; $display("FAIL mid_no_done: dones=%0d busy=%b required 0 0", done_cnt - d0, busy);
      end
      pulse_start();
      wait_done(400, n, ok);
      checks++;
      if (!ok || n != 257 || period !== 10'd256 || zero_seen !== 1'b1) begin
         errors++; $display("FAIL mid_remeasure: ok=%0d cycles=%0d period=%0d zero=%b required 1 257 256 1",
                            ok, n, period, zero_seen);
      end
   endtask

   initial begin
      test_reset();
      test_lfsr();
      test_gapped();
      test_constant(8'hA5);
      test_constant(8'h00);
      test_increment();
      test_restart();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
